// File: rtl/ip_pkt_framer.sv
// IP packet framer: buffers one packet, checks its word count against the header
// total-length field, then streams it out over a valid/ready handshake.
module ip_pkt_framer #(
  parameter int unsigned DEPTH = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pkg_data,
  input  logic        wr_en,
  input  logic        fin,
  output logic [31:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_sop,
  output logic        out_eop,
  output logic [15:0] out_len,
  output logic        busy,
  output logic        err_ovf,
  output logic        err_len,
  output logic        err_busy
);

  localparam int unsigned ADDR_W = $clog2(DEPTH);

  typedef enum logic [1:0] {StIdle, StFill, StSend, StDrop} state_e;

  state_e              state;
  logic [ADDR_W:0]     wr_cnt;
  logic [ADDR_W-1:0]   rd_ptr;
  logic [15:0]         exp_len;
  logic [31:0]         mem [DEPTH];

  logic                full;
  logic                accept;
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_waddr;
  logic [ADDR_W:0]     fill_cnt;
  logic [ADDR_W:0]     rd_next;
  logic [16:0]         fill_words;
  logic [16:0]         first_words;

  assign full        = (wr_cnt == (ADDR_W+1)'(DEPTH));
  assign accept      = wr_en && !full;
  // Count including a word that arrives together with fin.
  assign fill_cnt    = wr_cnt + (ADDR_W+1)'(accept);
  assign fill_words  = ({1'b0, exp_len} + 17'd3) >> 2;
  assign first_words = ({1'b0, pkg_data[15:0]} + 17'd3) >> 2;
  assign rd_next     = {1'b0, rd_ptr} + (ADDR_W+1)'(1);
  assign busy        = (state == StSend);

  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = wr_cnt[ADDR_W-1:0];
    if (state == StIdle) begin
      mem_we    = wr_en;
      mem_waddr = '0;
    end else if (state == StFill) begin
      mem_we = accept;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= pkg_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= StIdle;
      wr_cnt    <= '0;
      rd_ptr    <= '0;
      exp_len   <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_sop   <= 1'b0;
      out_eop   <= 1'b0;
      out_len   <= '0;
      err_ovf   <= 1'b0;
      err_len   <= 1'b0;
      err_busy  <= 1'b0;
    end else begin
      err_ovf  <= 1'b0;
      err_len  <= 1'b0;
      err_busy <= 1'b0;
      unique case (state)
        StIdle: begin
          if (wr_en) begin
            exp_len <= pkg_data[15:0];
            wr_cnt  <= (ADDR_W+1)'(1);
            if (!fin) begin
              state <= StFill;
            end else if (first_words == 17'd1) begin
              // One-word packet completed in the same cycle: bypass the RAM.
              state     <= StSend;
              rd_ptr    <= '0;
              out_len   <= 16'd1;
              out_data  <= pkg_data;
              out_valid <= 1'b1;
              out_sop   <= 1'b1;
              out_eop   <= 1'b1;
            end else begin
              err_len <= 1'b1;
            end
          end
        end
        StFill: begin
          if (wr_en && full) begin
            err_ovf <= 1'b1;
            state   <= fin ? StIdle : StDrop;
          end else begin
            wr_cnt <= fill_cnt;
            if (fin) begin
              if (17'(fill_cnt) == fill_words) begin
                state     <= StSend;
                rd_ptr    <= '0;
                out_len   <= 16'(fill_cnt);
                out_data  <= mem[0];
                out_valid <= 1'b1;
                out_sop   <= 1'b1;
                out_eop   <= (fill_cnt == (ADDR_W+1)'(1));
              end else begin
                err_len <= 1'b1;
                state   <= StIdle;
              end
            end
          end
        end
        StDrop: begin
          if (fin) begin
            state <= StIdle;
          end
        end
        StSend: begin
          err_busy <= wr_en;
          if (out_ready) begin
            if (out_eop) begin
              state     <= StIdle;
              rd_ptr    <= '0;
              out_valid <= 1'b0;
              out_sop   <= 1'b0;
              out_eop   <= 1'b0;
            end else begin
              // Prefetch the next word so back-to-back handshakes have no bubble.
              rd_ptr   <= rd_next[ADDR_W-1:0];
              out_data <= mem[rd_next[ADDR_W-1:0]];
              out_sop  <= 1'b0;
              out_eop  <= (16'(rd_next) == out_len - 16'd1);
            end
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_ip_pkt_framer.sv
// Bench for ip_pkt_framer: directed table, multi-cycle corner sequences and random
// packets scored against a packet-level reference model.
module tb_ip_pkt_framer;

  localparam int unsigned DEPTH = 64;

  typedef logic [31:0] wq_t[$];
  typedef struct packed {
    logic [31:0] data;
    logic        sop;
    logic        eop;
    logic [15:0] len;
  } beat_t;
  typedef struct packed {
    logic        w;
    logic        f;
    logic [31:0] d;
    logic        r;
    logic [2:0]  eflags;  // {out_valid, out_sop, out_eop}
    logic [31:0] edata;
    logic [15:0] elen;
    logic        ebusy;
    logic [2:0]  eerr;    // {err_ovf, err_len, err_busy}
  } vec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] pkg_data = '0;
  logic        wr_en = 1'b0;
  logic        fin = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_sop;
  logic        out_eop;
  logic [15:0] out_len;
  logic        busy;
  logic        err_ovf;
  logic        err_len;
  logic        err_busy;

  int    checks = 0;
  int    errors = 0;
  int    n_ovf = 0;
  int    n_len = 0;
  int    n_busy = 0;
  beat_t got[$];
  beat_t exp_q[$];

  ip_pkt_framer #(.DEPTH(DEPTH)) dut (
    .clk      (clk),
    .reset    (reset),
    .pkg_data (pkg_data),
    .wr_en    (wr_en),
    .fin      (fin),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_sop  (out_sop),
    .out_eop  (out_eop),
    .out_len  (out_len),
    .busy     (busy),
    .err_ovf  (err_ovf),
    .err_len  (err_len),
    .err_busy (err_busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, req);
    end
  endtask

  // One clock: drive inputs, log a handshake, then sample 1ns after the edge.
  task automatic cycle(input logic w, input logic [31:0] d, input logic f, input logic r);
    logic  stall;
    beat_t prev;
    wr_en     = w;
    pkg_data  = d;
    fin       = f;
    out_ready = r;
    prev  = {out_data, out_sop, out_eop, out_len};
    stall = out_valid && !r && !reset;
    if (out_valid && r && !reset) got.push_back(prev);
    @(posedge clk);
    #1;
    if (err_ovf) n_ovf++;
    if (err_len) n_len++;
    if (err_busy) n_busy++;
    if (stall) begin
      check("stall_valid", 32'(out_valid), 32'd1);
      check("stall_sop_eop", 32'({out_sop, out_eop}), 32'({prev.sop, prev.eop}));
      check("stall_data", out_data, prev.data);
      check("stall_len", 32'(out_len), 32'(prev.len));
    end
  endtask

  task automatic clear_counts();
    n_ovf  = 0;
    n_len  = 0;
    n_busy = 0;
    got.delete();
  endtask

  task automatic send_pkt(input wq_t w, input bit fin_last, input int max_gap);
    for (int i = 0; i < w.size(); i++) begin
      repeat ($urandom_range(max_gap, 0)) cycle(1'b0, '0, 1'b0, 1'b0);
      cycle(1'b1, w[i], fin_last && (i == w.size() - 1), 1'b0);
    end
    if (!fin_last) cycle(1'b0, '0, 1'b1, 1'b0);
  endtask

  // mode 0: always ready, 1: ready toggles starting high, other: random ready.
  task automatic drain(input int mode, output int vcycles);
    logic r;
    vcycles = 0;
    for (int i = 0; i < 400 && (out_valid || busy); i++) begin
      case (mode)
        0:       r = 1'b1;
        1:       r = (i % 2 == 0);
        default: r = 1'($urandom_range(1, 0));
      endcase
      vcycles++;
      cycle(1'b0, '0, 1'b0, r);
    end
    check("drain_done", 32'({out_valid, busy}), 32'd0);
  endtask

  function automatic int words_of(input logic [31:0] w0);
    return (int'(w0[15:0]) + 3) / 4;
  endfunction

  // Reference: decide the fate of a whole packet from its word list.
  task automatic model(input wq_t w, output int e_ovf, output int e_len);
    exp_q.delete();
    e_ovf = 0;
    e_len = 0;
    if (w.size() > DEPTH) e_ovf = 1;
    else if (w.size() != words_of(w[0])) e_len = 1;
    else foreach (w[i]) exp_q.push_back({w[i], i == 0, i == w.size() - 1, 16'(w.size())});
  endtask

  task automatic compare(input string tag, input int e_ovf, input int e_len, input int e_busy);
    check({tag, "_nwords"}, 32'(got.size()), 32'(exp_q.size()));
    for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
      check($sformatf("%s_data%0d", tag, i), got[i].data, exp_q[i].data);
      check($sformatf("%s_sopeop%0d", tag, i), 32'({got[i].sop, got[i].eop}),
            32'({exp_q[i].sop, exp_q[i].eop}));
      check($sformatf("%s_len%0d", tag, i), 32'(got[i].len), 32'(exp_q[i].len));
    end
    check({tag, "_err_ovf"}, 32'(n_ovf), 32'(e_ovf));
    check({tag, "_err_len"}, 32'(n_len), 32'(e_len));
    check({tag, "_err_busy"}, 32'(n_busy), 32'(e_busy));
    clear_counts();
  endtask

  function automatic wq_t mk_pkt(input int n, input int nbytes);
    wq_t q;
    q.push_back({16'h4500, 16'(nbytes)});
    for (int i = 1; i < n; i++) q.push_back($urandom);
    return q;
  endfunction

  initial begin
    vec_t        tbl[17];
    wq_t         pkt;
    wq_t         big;
    int          vc;
    int          e_ovf;
    int          e_len;
    int          ovf_at;
    int          vseen;
    logic [31:0] w0;
    logic [31:0] b0;

    w0 = 32'h4500_0014;
    b0 = 32'h4500_0018;
    // Good 5-word packet, fin with last word, then drained with ready high.
    tbl[0]  = {1'b1, 1'b0, w0,            1'b0, 3'b000, 32'h0,         16'd0, 1'b0, 3'b000};
    tbl[1]  = {1'b1, 1'b0, 32'hA000_0001, 1'b0, 3'b000, 32'h0,         16'd0, 1'b0, 3'b000};
    tbl[2]  = {1'b1, 1'b0, 32'hA000_0002, 1'b0, 3'b000, 32'h0,         16'd0, 1'b0, 3'b000};
    tbl[3]  = {1'b1, 1'b0, 32'hA000_0003, 1'b0, 3'b000, 32'h0,         16'd0, 1'b0, 3'b000};
    tbl[4]  = {1'b1, 1'b1, 32'hA000_0004, 1'b0, 3'b110, w0,            16'd5, 1'b1, 3'b000};
    tbl[5]  = {1'b0, 1'b0, 32'h0,         1'b1, 3'b100, 32'hA000_0001, 16'd5, 1'b1, 3'b000};
    tbl[6]  = {1'b0, 1'b0, 32'h0,         1'b1, 3'b100, 32'hA000_0002, 16'd5, 1'b1, 3'b000};
    tbl[7]  = {1'b0, 1'b0, 32'h0,         1'b1, 3'b100, 32'hA000_0003, 16'd5, 1'b1, 3'b000};
    tbl[8]  = {1'b0, 1'b0, 32'h0,         1'b1, 3'b101, 32'hA000_0004, 16'd5, 1'b1, 3'b000};
    tbl[9]  = {1'b0, 1'b0, 32'h0,         1'b1, 3'b000, 32'h0,         16'd0, 1'b0, 3'b000};
    // Header says 6 words, only 5 arrive, then a lone fin.
    tbl[10] = {1'b1, 1'b0, b0,            1'b0, 3'b000, 32'h0,         16'd0, 1'b0, 3'b000};
    tbl[11] = {1'b1, 1'b0, 32'hB000_0001, 1'b0, 3'b000, 32'h0,         16'd0, 1'b0, 3'b000};
    tbl[12] = {1'b1, 1'b0, 32'hB000_0002, 1'b0, 3'b000, 32'h0,         16'd0, 1'b0, 3'b000};
    tbl[13] = {1'b1, 1'b0, 32'hB000_0003, 1'b0, 3'b000, 32'h0,         16'd0, 1'b0, 3'b000};
    tbl[14] = {1'b1, 1'b0, 32'hB000_0004, 1'b0, 3'b000, 32'h0,         16'd0, 1'b0, 3'b000};
    tbl[15] = {1'b0, 1'b1, 32'h0,         1'b0, 3'b000, 32'h0,         16'd0, 1'b0, 3'b010};
    tbl[16] = {1'b0, 1'b0, 32'h0,         1'b0, 3'b000, 32'h0,         16'd0, 1'b0, 3'b000};

    reset = 1'b1;
    repeat (2) cycle(1'b0, '0, 1'b0, 1'b0);
    check("rst_flags", 32'({out_valid, out_sop, out_eop, busy}), 32'd0);
    check("rst_data", out_data, 32'd0);
    check("rst_len", 32'(out_len), 32'd0);
    check("rst_errs", 32'({err_ovf, err_len, err_busy}), 32'd0);
    reset = 1'b0;
    clear_counts();

    for (int i = 0; i < 17; i++) begin
      cycle(tbl[i].w, tbl[i].d, tbl[i].f, tbl[i].r);
      check($sformatf("tbl%0d_flags", i), 32'({out_valid, out_sop, out_eop}), 32'(tbl[i].eflags));
      if (tbl[i].eflags[2]) begin
        check($sformatf("tbl%0d_data", i), out_data, tbl[i].edata);
        check($sformatf("tbl%0d_len", i), 32'(out_len), 32'(tbl[i].elen));
      end
      check($sformatf("tbl%0d_busy", i), 32'(busy), 32'(tbl[i].ebusy));
      check($sformatf("tbl%0d_errs", i), 32'({err_ovf, err_len, err_busy}), 32'(tbl[i].eerr));
    end
    clear_counts();

    // Ready toggling: 5 accepts and 4 stalls keep out_valid high for 9 cycles.
    pkt = {w0, 32'hC000_0001, 32'hC000_0002, 32'hC000_0003, 32'hC000_0004};
    send_pkt(pkt, 1'b1, 0);
    check("toggle_first", 32'({out_valid, out_sop}), 32'd3);
    drain(1, vc);
    check("toggle_valid_cycles", 32'(vc), 32'd9);
    model(pkt, e_ovf, e_len);
    compare("toggle", e_ovf, e_len, 0);

    // Overflow: 70 words into a 64-word buffer.
    big    = mk_pkt(70, 280);
    ovf_at = 0;
    vseen  = 0;
    for (int i = 0; i < 70; i++) begin
      cycle(1'b1, big[i], i == 69, 1'b1);
      if (err_ovf && ovf_at == 0) ovf_at = i + 1;
      if (out_valid) vseen++;
    end
    cycle(1'b0, '0, 1'b0, 1'b1);
    check("ovf_word", 32'(ovf_at), 32'd65);
    check("ovf_no_output", 32'(vseen), 32'd0);
    check("ovf_idle", 32'({out_valid, busy}), 32'd0);
    model(big, e_ovf, e_len);
    compare("ovf", e_ovf, e_len, 0);
    send_pkt(pkt, 1'b0, 1);
    drain(2, vc);
    model(pkt, e_ovf, e_len);
    compare("after_ovf", e_ovf, e_len, 0);

    // Writes during SEND are rejected and do not disturb the packet.
    send_pkt(pkt, 1'b1, 0);
    for (int k = 1; k <= 5; k++) cycle(k <= 3, 32'hDEAD_0000, 1'b0, 1'b1);
    drain(0, vc);
    model(pkt, e_ovf, e_len);
    compare("busy", e_ovf, e_len, 3);

    // Reset while the third word is on the output.
    send_pkt(pkt, 1'b1, 0);
    cycle(1'b0, '0, 1'b0, 1'b1);
    cycle(1'b0, '0, 1'b0, 1'b1);
    check("rstsend_third", out_data, 32'hC000_0002);
    reset = 1'b1;
    cycle(1'b0, '0, 1'b0, 1'b1);
    check("rstsend_idle", 32'({out_valid, busy}), 32'd0);
    reset = 1'b0;
    clear_counts();
    pkt = {32'h4500_0004};
    send_pkt(pkt, 1'b0, 0);
    check("one_word_flags", 32'({out_valid, out_sop, out_eop}), 32'd7);
    check("one_word_data", out_data, 32'h4500_0004);
    drain(0, vc);
    model(pkt, e_ovf, e_len);
    compare("one_word", e_ovf, e_len, 0);

    // Random packets: good, wrong length and overflowing, random gaps and ready.
    for (int p = 0; p < 30; p++) begin
      int unsigned kind;
      int          n;
      int          nbytes;
      bit          fin_last;
      kind = $urandom_range(9, 0);
      if (kind == 0) begin
        n      = $urandom_range(72, 65);
        nbytes = n * 4;
      end else if (kind <= 2) begin
        n = $urandom_range(16, 1);
        if (n == 1 || $urandom % 2 == 1) nbytes = (n + 1 + int'($urandom_range(3, 0))) * 4;
        else nbytes = (n - 1) * 4;
      end else begin
        n      = $urandom_range(16, 1);
        nbytes = n * 4 - int'($urandom_range(3, 0));
      end
      fin_last = (n > 1) && ($urandom % 2 == 1);
      pkt = mk_pkt(n, nbytes);
      send_pkt(pkt, fin_last, 2);
      drain(2, vc);
      model(pkt, e_ovf, e_len);
      compare($sformatf("rnd%0d", p), e_ovf, e_len, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
